// File: rtl/multicycle_controller.sv
// Main control FSM with ALU and immediate decoders for a multicycle RV32I datapath.
// Optional BNE_EN macro: funct3[0] inverts the branch condition so bne branches on not-equal.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  state_t state, next_state;
  aluop_t aluop;
  logic   pcupdate;
  logic   branch;
  logic   irwrite_raw;
  logic   regwrite_raw;
  logic   memwrite_raw;
  logic   branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Unused codes 11-15 fall through the default and recover to FETCH.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_IALU:      next_state = EXECUTEI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      JAL:      next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    resultsrc    = 2'b00;
    adrsrc       = 1'b0;
    aluop        = ALUOP_ADD;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    case (state)
      FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        pcupdate    = 1'b1;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD:  adrsrc = 1'b1;
      MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXECUTER: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB:    regwrite_raw = 1'b1;
      JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // op[5] separates R-type from I-type, so addi never turns into a subtract.
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALUOP_ADD: alucontrol = 3'b000;
      ALUOP_SUB: alucontrol = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    immsrc = 2'b00;
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

`ifdef BNE_EN
  assign branch_taken = branch & (zero ^ funct3[0]);
`else
  assign branch_taken = branch & zero;
`endif

  // The state register already sits in FETCH during reset, so only the enables need masking.
  assign irwrite  = irwrite_raw  & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign pcwrite  = (pcupdate | branch_taken) & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, reset aborts and random instruction streams.
// Honours BNE_EN in its reference model when the macro is defined.
module tb_multicycle_controller;

  typedef struct packed {
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
  } ctl_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    int         zmode;
    int         latency;
  } vec_t;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IALU = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JALO = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite;
  ctl_t       actual;

  int checks   = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
    .adrsrc(adrsrc), .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memwrite(memwrite)
  );

  always #5 clk = ~clk;

  assign actual = '{immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                    irwrite, pcwrite, regwrite, memwrite};

  // Instruction class: 0 lw, 1 sw, 2 R, 3 I-ALU, 4 jal, 5 branch, 6 nop.
  function automatic int classify(input logic [6:0] o);
    case (o)
      LW:      return 0;
      SW:      return 1;
      RT:      return 2;
      IALU:    return 3;
      JALO:    return 4;
      BR:      return 5;
      default: return 6;
    endcase
  endfunction

  function automatic int latency_of(input logic [6:0] o);
    case (classify(o))
      0:       return 5;
      5:       return 3;
      6:       return 2;
      default: return 4;
    endcase
  endfunction

  // Arithmetic the instruction asks for; only a register-register funct3 000 with bit 30 set subtracts.
  function automatic logic [2:0] arith(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z);
`ifdef BNE_EN
    return z ^ f3[0];
`else
    return z;
`endif
  endfunction

  // Expected control word in cycle k (0 = fetch) of an instruction.
  function automatic ctl_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input int k);
    ctl_t e;
    int   c;
    e = '0;
    c = classify(o);
    case (c)
      1:       e.immsrc = 2'b01;
      5:       e.immsrc = 2'b10;
      4:       e.immsrc = 2'b11;
      default: e.immsrc = 2'b00;
    endcase
    if (k == 0) begin
      e.alusrcb = 2'b10; e.resultsrc = 2'b10; e.irwrite = 1'b1; e.pcwrite = 1'b1;
    end else if (k == 1) begin
      e.alusrca = 2'b01; e.alusrcb = 2'b01;
    end else begin
      case (c)
        0: begin
          if (k == 2) begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
          if (k == 3) e.adrsrc = 1'b1;
          if (k == 4) begin e.resultsrc = 2'b01; e.regwrite = 1'b1; end
        end
        1: begin
          if (k == 2) begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
          if (k == 3) begin e.adrsrc = 1'b1; e.memwrite = 1'b1; end
        end
        2: begin
          if (k == 2) begin e.alusrca = 2'b10; e.alucontrol = arith(f3, f7, 1'b1); end
          if (k == 3) e.regwrite = 1'b1;
        end
        3: begin
          if (k == 2) begin
            e.alusrca = 2'b10; e.alusrcb = 2'b01; e.alucontrol = arith(f3, f7, 1'b0);
          end
          if (k == 3) e.regwrite = 1'b1;
        end
        4: begin
          if (k == 2) begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1; end
          if (k == 3) e.regwrite = 1'b1;
        end
        5: begin
          e.alusrca = 2'b10; e.alucontrol = 3'b001; e.pcwrite = taken(f3, z);
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input ctl_t exp);
    checks++;
    if (actual !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (imm,a,b,res,adr,alu,ir,pc,rw,mw)",
               name, actual, exp);
    end
  endtask

  // Entered just after a rising edge with the FSM in FETCH; leaves it likewise unless cut short.
  task automatic applyStimulus(input string name, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input int zmode, input int ncycles);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int k = 0; k < ncycles; k++) begin
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      checkOutput($sformatf("%s_c%0d", name, k), model(o, f3, f7, zero, k));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkReset(input string name);
    ctl_t e;
    e = model(op, funct3, funct7b5, zero, 0);
    e.irwrite = 1'b0;
    e.pcwrite = 1'b0;
    checkOutput(name, e);
  endtask

  task automatic resetAbort(input string name);
    reset = 1'b1;
    #1;
    checkReset({name, "_assert"});
    @(negedge clk);
    checkReset({name, "_held"});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{"lw",      LW,        3'b010, 1'b0, 0, 5});
    vecs.push_back('{"sw",      SW,        3'b010, 1'b0, 1, 4});
    vecs.push_back('{"add",     RT,        3'b000, 1'b0, 0, 4});
    vecs.push_back('{"sub",     RT,        3'b000, 1'b1, 0, 4});
    vecs.push_back('{"or",      RT,        3'b110, 1'b0, 0, 4});
    vecs.push_back('{"and",     RT,        3'b111, 1'b0, 0, 4});
    vecs.push_back('{"slt",     RT,        3'b010, 1'b0, 0, 4});
    vecs.push_back('{"sll",     RT,        3'b001, 1'b1, 0, 4});
    vecs.push_back('{"addi_f7", IALU,      3'b000, 1'b1, 0, 4});
    vecs.push_back('{"ori",     IALU,      3'b110, 1'b1, 0, 4});
    vecs.push_back('{"andi",    IALU,      3'b111, 1'b0, 0, 4});
    vecs.push_back('{"slti",    IALU,      3'b010, 1'b0, 0, 4});
    vecs.push_back('{"beq_z1",  BR,        3'b000, 1'b0, 1, 3});
    vecs.push_back('{"beq_z0",  BR,        3'b000, 1'b0, 0, 3});
    vecs.push_back('{"bne_z0",  BR,        3'b001, 1'b0, 0, 3});
    vecs.push_back('{"bne_z1",  BR,        3'b001, 1'b0, 1, 3});
    vecs.push_back('{"jal",     JALO,      3'b000, 1'b0, 0, 4});
    vecs.push_back('{"nop_7f",  7'b1111111, 3'b000, 1'b0, 1, 2});
    vecs.push_back('{"nop_00",  7'b0000000, 3'b111, 1'b1, 1, 2});

    reset = 1'b1; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
    @(negedge clk);
    checkReset("power_on_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      checks++;
      if (latency_of(vecs[i].op) != vecs[i].latency) begin
        failures++;
        $display("[TB] FAIL %s_latency_table actual=%0d expected=%0d", vecs[i].name,
                 latency_of(vecs[i].op), vecs[i].latency);
      end
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].funct3, vecs[i].funct7b5,
                    vecs[i].zmode, vecs[i].latency);
    end

    // Abort a load in MEMREAD, then a load in MEMWB where regwrite would otherwise fire.
    applyStimulus("lw_abort_memread", LW, 3'b010, 1'b0, 0, 3);
    resetAbort("rst_memread");
    applyStimulus("sw_after_rst", SW, 3'b010, 1'b0, 0, 4);
    applyStimulus("lw_abort_memwb", LW, 3'b010, 1'b0, 0, 4);
    resetAbort("rst_memwb");
    applyStimulus("sw_abort_memwrite", SW, 3'b010, 1'b0, 0, 3);
    resetAbort("rst_memwrite");
    applyStimulus("jal_after_rst", JALO, 3'b000, 1'b0, 0, 4);

    for (int n = 0; n < 150; n++) begin
      logic [6:0] ops[7];
      logic [6:0] o;
      int         pick;
      ops = '{LW, SW, RT, IALU, BR, JALO, 7'b1110011};
      pick = int'($urandom_range(0, 7));
      o = (pick == 7) ? 7'($urandom) : ops[pick];
      applyStimulus($sformatf("rand%0d", n), o, 3'($urandom), 1'($urandom), 2, latency_of(o));
    end

    applyStimulus("final_fetch", 7'b1111111, 3'b000, 1'b0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style main FSM plus ALU and immediate decoders that sequence the shared multicycle RV32I datapath: a single memory, a single ALU, and the immediate extender. It issues per-state mux selects and write enables for the PC, instruction register, register file and memory. It consumes the instruction fields and the ALU zero flag. It replaces the single-cycle control path. The ALU, register file and extender are shared across cycles under this block's control.

Parameters:
none (state encoding fixed below; no tunables)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces state to FETCH
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag (combinational from current ALU result)
immsrc  output  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
alusrca  output  2  00 PC, 01 OldPC, 10 register A
alusrcb  output  2  00 register WriteData, 01 ImmExt, 10 constant 4
resultsrc  output  2  00 ALUOut, 01 Data register, 10 ALUResult
adrsrc  output  1  memory address: 0 PC, 1 Result
alucontrol  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
irwrite  output  1  instruction register load
pcwrite  output  1  PC load
regwrite  output  1  register file write
memwrite  output  1  data memory write

Behaviour:
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- State register is 4 bits, async reset to FETCH. Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11-15 go to FETCH on the next edge.
- Transitions:
  - FETCH->DECODE.
  - DECODE: lw/sw->MEMADR; R->EXECUTER; I-ALU->EXECUTEI; jal->JAL; beq->BEQ; any other op->FETCH (treated as nop).
  - MEMADR: lw->MEMREAD, sw->MEMWRITE.
  - MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH.
  - EXECUTER, EXECUTEI, JAL->ALUWB. ALUWB->FETCH. BEQ->FETCH.
- Per-state outputs; any output not listed is 0 / 00, and aluop is internal:
  - FETCH: adrsrc 0, irwrite 1, alusrca 00, alusrcb 10, aluop add, resultsrc 10, pcupdate 1.
  - DECODE: alusrca 01, alusrcb 01, aluop add (branch target precompute).
  - MEMADR: alusrca 10, alusrcb 01, aluop add.
  - MEMREAD: resultsrc 00, adrsrc 1.
  - MEMWB: resultsrc 01, regwrite 1.
  - MEMWRITE: resultsrc 00, adrsrc 1, memwrite 1.
  - EXECUTER: alusrca 10, alusrcb 00, aluop funct.
  - EXECUTEI: alusrca 10, alusrcb 01, aluop funct.
  - ALUWB: resultsrc 00, regwrite 1.
  - JAL: alusrca 01, alusrcb 10, aluop add, resultsrc 00, pcupdate 1.
  - BEQ: alusrca 10, alusrcb 00, aluop sub, resultsrc 00, branch 1.
- pcwrite = pcupdate | (branch & zero).
- ALU decode:
  - aluop add -> 000; aluop sub -> 001.
  - aluop funct, by funct3:
    - 000: sub (001) when op[5]&funct7b5, else add (000).
    - 010 -> slt 101; 110 -> or 011; 111 -> and 010; other funct3 -> 000.
- immsrc is combinational from op, independent of state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
- Latency in cycles: lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3, unknown op 2.
- Reset:
  - While reset is high, irwrite, pcwrite, regwrite and memwrite are forced 0.
  - Selects and immsrc take FETCH/op-derived values.
  - Reset asserted mid-instruction aborts it immediately; no partial write after deassertion.
  - The first rising edge after deassertion executes FETCH.
- zero is sampled only in BEQ; it is a don't-care elsewhere.

Optional Feature:
BNE_EN:
- Defined: in BEQ, pcwrite = branch & (zero ^ funct3[0]), so funct3 001 (bne) branches when not equal.
- Undefined: pcwrite = branch & zero regardless of funct3, so bne behaves as beq.
- Opcode, state sequence and latency are identical either way.

Test Plan:
- Reset high in state MEMREAD, held 1 cycle, released -> state FETCH; all write enables 0 during reset; irwrite=1 and pcwrite=1 on the first cycle after release.
- lw x5,8(x1) (op 0000011) -> states 0,1,2,3,4; regwrite=1 only in cycle 5 with resultsrc=01; immsrc=00 throughout.
- sw (op 0100011) -> states 0,1,2,5; memwrite=1 only in cycle 4 with adrsrc=1; immsrc=01; regwrite never 1.
- sub R-type (funct3 000, funct7b5 1) -> alucontrol=001 in EXECUTER; addi with funct7b5 1 -> alucontrol=000 in EXECUTEI; or/and/slt give 011/010/101.
- beq with zero=1 -> pcwrite=1 in BEQ; zero=0 -> pcwrite=0. With BNE_EN, funct3 001 and zero=0 -> pcwrite=1. Each branch returns to FETCH after 3 cycles.
- jal (op 1101111) -> states 0,1,9,7; pcwrite=1 in JAL; regwrite=1 in ALUWB; immsrc=11. Op 1111111 -> DECODE->FETCH with no write enables asserted.
